axis_ifmaps_rx_fifo: RTL
========================

# axis_ifmaps_rx_fifo

AXI4-Stream slave front end for the ifmaps path. Accepts 32-bit beats from the DMA stream, checks that each transfer ends on a MAC-vector boundary, and buffers beats in a first-word-fall-through FIFO. Sits directly upstream of the ifmaps preload stage, which pops words through the `fifo_empty` / `fifo_read` pair and assembles them into 5*MAC_NUM-bit vectors.

## Interface
- `C_S_AXIS_TDATA_WIDTH`, 32, stream beat width; fixed at 32.
- `MAC_NUM`, 256, MAC count; one vector is 5*MAC_NUM bits.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, at least 2.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_axis_tdata`  in  32  stream data.
- `s_axis_tvalid`  in  1  stream valid.
- `s_axis_tready`  out  1  stream ready.
- `s_axis_tlast`  in  1  end of ifmap transfer.
- `fifo_dout`  out  32  head word, FWFT.
- `fifo_empty`  out  1  no word available.
- `fifo_read`  in  1  pop head word.
- `fifo_count`  out  clog2(FIFO_DEPTH+1)  occupancy.
- `frame_done`  out  1  one-cycle pulse when the last word of a vector is written.
- `frame_err`  out  1  sticky flag: `tlast` arrived off a vector boundary.

## Operation
- `FRAME_WORDS` = 5*MAC_NUM/32 (40 at default). `word_cnt` counts 0..FRAME_WORDS-1 and wraps to 0.
- Write: a beat is accepted when `s_axis_tvalid && s_axis_tready`. The beat is written at `wr_ptr`, then `wr_ptr` and `word_cnt` advance.
- `s_axis_tready` = state is RECV and FIFO is not full. It does not depend on `fifo_read` in the same cycle.
- Read: a pop happens when `fifo_read && !fifo_empty`. A `fifo_read` while empty is ignored and does not move `rd_ptr`.
- Pointers wrap modulo FIFO_DEPTH. `fifo_count` increments on write only, decrements on pop only, and holds when both happen in the same cycle.
- `fifo_dout` = `mem[rd_ptr]` when not empty, otherwise 0.
- `frame_done` pulses on any write (stream or pad) with `word_cnt == FRAME_WORDS-1`.
- `tlast` check:
  - `tlast` accepted with `word_cnt == FRAME_WORDS-1` is legal.
  - Otherwise `frame_err` is set and stays set until reset.
- State machine (RECV, PAD):
  - RECV → PAD on an illegal `tlast`, only when padding is compiled in.
  - In PAD, one zero word is written per cycle while the FIFO is not full.
  - PAD → RECV after the pad write with `word_cnt == FRAME_WORDS-1`.

## Timing
- Reset (`rst_n` low at a clock edge):
  - `s_axis_tready` = 0, `fifo_empty` = 1, `fifo_count` = 0, `fifo_dout` = 0, `frame_done` = 0, `frame_err` = 0.
  - Pointers, `word_cnt` and state (RECV) are cleared. Memory contents are not reset.
  - Reset mid-frame or mid-pad discards all state. `tready` rises the first cycle after `rst_n` is high.
- Write-to-read latency: a word written at edge N shows `fifo_empty` = 0 and valid `fifo_dout` after edge N.
- Pop at edge N: `fifo_dout` shows the next word after edge N.
- Full: `s_axis_tready` = 0. A same-cycle pop frees an entry for the next cycle, not the current one.
- Simultaneous pop and write while empty: the pop is ignored and the write is stored.
- `frame_done` and `frame_err` are registered and assert the cycle after the causing write.

## Configuration
- Macro `AXIS_IFMAPS_PAD_EN`.
- Defined: an illegal `tlast` sets `frame_err` and enters PAD. The FIFO always receives whole vectors, so the downstream stage never stalls on a partial vector.
- Undefined: an illegal `tlast` only sets `frame_err`. The state stays RECV and `word_cnt` keeps counting, so the next transfer continues the partial vector. The PAD state is not built.

## Structure
- Shared package `axis_ifmaps_pkg` holds:
  - `FRAME_WORDS` derivation and the `clogb2` function.
  - State encoding constants `ST_RECV`, `ST_PAD`.
  - Both are also used by the preload stage.
- Sub-module `sync_fifo_fwft` contains the storage, pointers and count, and exposes write enable/data and pop.
- The top level holds the AXIS handshake, `word_cnt`, the FSM and the flags.

## Test plan
- Stream 80 beats with `tlast` on beat 80, `fifo_read` held 1 → 80 words out in order, `frame_done` pulses twice (after beats 40 and 80), `frame_err` = 0.
- Stream 17 beats with no reads, FIFO_DEPTH = 16 → `tready` = 0 after 16 writes, `fifo_count` = 16. One pop → `tready` = 1 next cycle and beat 17 is accepted.
- `tlast` on beat 10 with `AXIS_IFMAPS_PAD_EN` defined → `frame_err` = 1, `tready` = 0 for 30 cycles, 30 zero words written, `frame_done` pulses once, then back to RECV.
- Same stimulus without the macro → `frame_err` = 1, no zero words. The next 30 beats complete the vector and `frame_done` pulses on the 40th total.
- `fifo_read` pulses while empty, then one write of 0xDEADBEEF → `rd_ptr` unchanged, `fifo_dout` = 0xDEADBEEF the cycle after the write.
- `rst_n` low for 1 cycle during PAD with 5 words buffered → all outputs at reset values. After release, `tready` = 1 and a new 40-beat frame passes cleanly.

Source files
------------

// File: rtl/axis_ifmaps_pkg.sv
// Definitions shared by the ifmaps receive FIFO and the ifmaps preload stage:
// vector framing, width helper and the receive state encoding.
package axis_ifmaps_pkg;

    localparam int MAC_NUM_DEFAULT    = 256;
    localparam int BEAT_WIDTH_DEFAULT = 32;

    typedef enum logic [0:0] {
        ST_RECV = 1'b0,
        ST_PAD  = 1'b1
    } rxState_e;

    // Ceiling log2; clogb2(1) is 0, so callers that need a real bit use max(...,1).
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Stream beats that make up one 5*MAC_NUM-bit vector.
    function automatic int frameWords(input int macNum, input int beatWidth);
        return (5 * macNum) / beatWidth;
    endfunction

    localparam int FRAME_WORDS = frameWords(MAC_NUM_DEFAULT, BEAT_WIDTH_DEFAULT);

endpackage

// File: rtl/axis_ifmaps_rx_fifo_if.sv
// Stream input, FIFO read port and frame status of the ifmaps receive FIFO.
interface axis_ifmaps_rx_fifo_if
    import axis_ifmaps_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    localparam int CNT_W     = clogb2(FIFO_DEPTH + 1)
);
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_read;
    logic [CNT_W-1:0]  fifo_count;
    logic              frame_done;
    logic              frame_err;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_read,
        output s_axis_tready, fifo_dout, fifo_empty, fifo_count, frame_done, frame_err
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, fifo_read,
        input  s_axis_tready, fifo_dout, fifo_empty, fifo_count, frame_done, frame_err
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head word is visible on dout_o whenever not empty.
// Writes while full and pops while empty are ignored.
module sync_fifo_fwft
    import axis_ifmaps_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = (DEPTH > 1) ? clogb2(DEPTH) : 1,
    localparam int CW    = clogb2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [CW-1:0]     count_o
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign push    = wr_en_i && !full_o;
    assign pop     = rd_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem[rdPtr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/axis_ifmaps_rx_fifo.sv
// AXI4-Stream slave front end for the ifmaps path: vector-boundary tlast check feeding an FWFT FIFO.
// Define AXIS_IFMAPS_PAD_EN to zero-pad truncated vectors so the FIFO only ever holds whole vectors.
module axis_ifmaps_rx_fifo
    import axis_ifmaps_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int MAC_NUM              = 256,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axis_ifmaps_rx_fifo_if.slave bus
);
    localparam int FRAME_WORDS_L       = frameWords(MAC_NUM, C_S_AXIS_TDATA_WIDTH);
    localparam int WCW                 = (FRAME_WORDS_L > 1) ? clogb2(FRAME_WORDS_L) : 1;
    localparam int CW                  = clogb2(FIFO_DEPTH + 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS_L - 1);

    logic [WCW-1:0] wordCnt_q, wordCnt_d;
    logic           armed_q;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic                            recvState, padWrite;
    logic                            tready, accept, badLast, lastWord, wrEn;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] wrData;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] fifoDout;
    logic                            fifoFull, fifoEmpty;
    logic [CW-1:0]                   fifoCount;

    // armed_q keeps tready low until the first edge that sees reset released.
    assign lastWord = (wordCnt_q == LAST_WORD);
    assign tready   = armed_q && recvState && !fifoFull;
    assign accept   = tready && bus.s_axis_tvalid;
    assign badLast  = accept && bus.s_axis_tlast && !lastWord;
    assign wrEn     = accept || padWrite;
    assign wrData   = padWrite ? '0 : bus.s_axis_tdata;

`ifdef AXIS_IFMAPS_PAD_EN
    rxState_e state_q, state_d;

    assign recvState = (state_q == ST_RECV);
    assign padWrite  = (state_q == ST_PAD) && !fifoFull;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RECV: if (badLast) state_d = ST_PAD;
            ST_PAD:  if (padWrite && lastWord) state_d = ST_RECV;
            default: state_d = ST_RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RECV;
        end else begin
            state_q <= state_d;
        end
    end
`else
    assign recvState = 1'b1;
    assign padWrite  = 1'b0;
`endif

    // Every write, stream or pad, advances the position within the current vector.
    always_comb begin
        wordCnt_d = wordCnt_q;
        done_d    = 1'b0;
        err_d     = err_q | badLast;
        if (wrEn) begin
            wordCnt_d = lastWord ? '0 : wordCnt_q + WCW'(1);
            done_d    = lastWord;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wordCnt_q <= '0;
            armed_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wordCnt_q <= wordCnt_d;
            armed_q   <= 1'b1;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    sync_fifo_fwft #(
        .DATA_W (C_S_AXIS_TDATA_WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wrEn),
        .wr_data_i (wrData),
        .rd_i      (bus.fifo_read),
        .dout_o    (fifoDout),
        .empty_o   (fifoEmpty),
        .full_o    (fifoFull),
        .count_o   (fifoCount)
    );

    assign bus.s_axis_tready = tready;
    assign bus.fifo_dout     = fifoDout;
    assign bus.fifo_empty    = fifoEmpty;
    assign bus.fifo_count    = fifoCount;
    assign bus.frame_done    = done_q;
    assign bus.frame_err     = err_q;

endmodule
